// File: rtl/act_pipe.sv
// Multi-lane activation stage: a capture register, then a compute/output register,
// with full valid/ready backpressure and a saturating count of negative-zeroed lanes.
module act_pipe #(
  parameter int DATA_W = 23,
  parameter int LANES  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                cfg_mode_i,
  input  logic [DATA_W-2:0]         cfg_clip_i,
  input  logic [2:0]                cfg_shift_i,
  input  logic [LANES*DATA_W-1:0]   in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [LANES*DATA_W-1:0]   out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  input  logic                      clr_cnt_i,
  output logic [CNT_W-1:0]          zero_cnt_o
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_CLIP   = 2'd2,
    MODE_LEAKY  = 2'd3
  } mode_e;

  logic                    s1_valid_q;
  logic [LANES*DATA_W-1:0] s1_data_q;
  mode_e                   s1_mode_q;
  logic [DATA_W-2:0]       s1_clip_q;
  logic [2:0]              s1_shift_q;

  logic                    s2_valid_q;
  logic [LANES*DATA_W-1:0] s2_data_q;
  logic [LANES-1:0]        s2_zero_q;

  logic [LANES*DATA_W-1:0] res_d;
  logic [LANES-1:0]        zero_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W:0]          pop_d, sum_d;
  logic                    adv1, adv2;

  assign adv2        = !s2_valid_q || out_ready_i;
  assign adv1        = !s1_valid_q || adv2;
  assign in_ready_o  = adv1;
  assign out_valid_o = s2_valid_q;
  assign out_data_o  = s2_data_q;
  assign zero_cnt_o  = cnt_q;

  // Each beat carries its own configuration so in-flight beats are unaffected by cfg changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_BYPASS;
      s1_clip_q  <= '0;
      s1_shift_q <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_data_q  <= in_data_i;
        s1_mode_q  <= mode_e'(cfg_mode_i);
        s1_clip_q  <= cfg_clip_i;
        s1_shift_q <= cfg_shift_i;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic                     zf;

    assign x = s1_data_q[g*DATA_W +: DATA_W];

    // Clip compare treats a non-negative sample as an unsigned DATA_W-1 magnitude.
    always_comb begin
      y  = x;
      zf = 1'b0;
      unique case (s1_mode_q)
        MODE_RELU: begin
          if (x[DATA_W-1]) begin
            y  = '0;
            zf = 1'b1;
          end
        end
        MODE_CLIP: begin
          if (x[DATA_W-1]) begin
            y  = '0;
            zf = 1'b1;
          end else if (x[DATA_W-2:0] > s1_clip_q) begin
            y = {1'b0, s1_clip_q};
          end
        end
        MODE_LEAKY: begin
          if (x[DATA_W-1]) y = x >>> s1_shift_q;
        end
        default: ;
      endcase
    end

    assign res_d[g*DATA_W +: DATA_W] = y;
    assign zero_d[g]                 = zf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_zero_q  <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= res_d;
        s2_zero_q <= zero_d;
      end
    end
  end

  // One extra sum bit detects overflow so the counter pins at all-ones.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < LANES; i++) pop_d = pop_d + (CNT_W+1)'(s2_zero_q[i]);
    sum_d = {1'b0, cnt_q} + pop_d;
    cnt_d = cnt_q;
    if (clr_cnt_i) cnt_d = '0;
    else if (s2_valid_q && out_ready_i) cnt_d = sum_d[CNT_W] ? '1 : sum_d[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_act_pipe.sv
// Randomized and directed bench for act_pipe against a beat-queue reference model,
// with a second instance using a 4-bit counter to exercise saturation.
module tb_act_pipe;

  localparam int DW = 23;
  localparam int L  = 4;
  localparam int W  = DW * L;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cfgMode;
  logic [DW-2:0] cfgClip;
  logic [2:0]    cfgShift;
  logic [W-1:0]  inData;
  logic          inValid;
  logic          inReady, satInReady;
  logic [W-1:0]  outData, satOutData;
  logic          outValid, satOutValid;
  logic          outReady;
  logic          clrCnt;
  logic [31:0]   zeroCnt;
  logic [3:0]    satZeroCnt;

  always #5 clk = ~clk;

  act_pipe #(.DATA_W(DW), .LANES(L), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cfg_mode_i(cfgMode), .cfg_clip_i(cfgClip), .cfg_shift_i(cfgShift),
    .in_data_i(inData), .in_valid_i(inValid), .in_ready_o(inReady),
    .out_data_o(outData), .out_valid_o(outValid), .out_ready_i(outReady),
    .clr_cnt_i(clrCnt), .zero_cnt_o(zeroCnt)
  );

  act_pipe #(.DATA_W(DW), .LANES(L), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .cfg_mode_i(cfgMode), .cfg_clip_i(cfgClip), .cfg_shift_i(cfgShift),
    .in_data_i(inData), .in_valid_i(inValid), .in_ready_o(satInReady),
    .out_data_o(satOutData), .out_valid_o(satOutValid), .out_ready_i(outReady),
    .clr_cnt_i(clrCnt), .zero_cnt_o(satZeroCnt)
  );

  typedef struct {
    logic [W-1:0] data;
    int           zeros;
    int           age;
  } beat_t;

  beat_t        pipeQ[$];
  longint       modelCnt, modelSatCnt;
  int           checks = 0;
  int           passes = 0;
  logic [W-1:0] stimData, fixedExp;
  bit           useFixed;
  int           stimMode, stimClip, stimShift;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  function automatic logic [W-1:0] pack4(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Plain-integer reference of one lane's activation.
  function automatic logic [DW-1:0] actLane(input logic [DW-1:0] raw, input int mode, clip, shift,
                                            output int zero);
    int x, y;
    x = raw[DW-1] ? int'(raw) - (1 << DW) : int'(raw);
    y = x;
    zero = 0;
    case (mode)
      1: if (x < 0) begin y = 0; zero = 1; end
      2: if (x < 0) begin y = 0; zero = 1; end else if (x > clip) y = clip;
      3: if (x < 0) y = x >>> shift;
      default: ;
    endcase
    return DW'(y);
  endfunction

  function automatic beat_t modelBeat(input logic [W-1:0] data, input int mode, clip, shift);
    beat_t b;
    int z;
    b.zeros = 0;
    b.age = 1;
    b.data = '0;
    for (int i = 0; i < L; i++) begin
      b.data[i*DW +: DW] = actLane(data[i*DW +: DW], mode, clip, shift, z);
      b.zeros += z;
    end
    return b;
  endfunction

  function automatic logic [DW-1:0] randLane();
    case ($urandom_range(0, 2))
      0:       return DW'($urandom());
      1:       return DW'($urandom_range(0, 300));
      default: return DW'((1 << DW) - int'($urandom_range(1, 300)));
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, check, advance the model, check counters.
  task automatic applyStimulus(input bit valid, input bit ready, input bit clr, output bit accepted);
    beat_t b;
    bit expIn, expValid, transfer;
    inValid  = valid;
    outReady = ready;
    clrCnt   = clr;
    inData   = stimData;
    cfgMode  = 2'(stimMode);
    cfgClip  = (DW-1)'(stimClip);
    cfgShift = 3'(stimShift);
    #1;
    expIn    = (pipeQ.size() < 2) || ready;
    expValid = (pipeQ.size() > 0) && (pipeQ[0].age >= 2);
    checkOutput("in_ready", inReady, expIn);
    checkOutput("sat_in_ready", satInReady, expIn);
    checkOutput("out_valid", outValid, expValid);
    checkOutput("sat_out_valid", satOutValid, expValid);
    if (expValid) begin
      checkOutput("out_data", outData, pipeQ[0].data);
      checkOutput("sat_out_data", satOutData, pipeQ[0].data);
    end
    transfer = expValid && ready;
    if (clr) begin
      modelCnt = 0;
      modelSatCnt = 0;
    end else if (transfer) begin
      modelCnt    = modelCnt + pipeQ[0].zeros;
      modelSatCnt = modelSatCnt + pipeQ[0].zeros;
      if (modelCnt > 64'hFFFF_FFFF) modelCnt = 64'hFFFF_FFFF;
      if (modelSatCnt > 15) modelSatCnt = 15;
    end
    if (transfer) void'(pipeQ.pop_front());
    foreach (pipeQ[i]) pipeQ[i].age++;
    accepted = valid && expIn;
    if (accepted) begin
      b = modelBeat(stimData, stimMode, stimClip, stimShift);
      if (useFixed) b.data = fixedExp;
      pipeQ.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("zero_cnt", zeroCnt, modelCnt);
    checkOutput("sat_zero_cnt", satZeroCnt, modelSatCnt);
  endtask

  task automatic drain();
    bit a;
    int n = 0;
    while (pipeQ.size() > 0 && n < 50) begin
      applyStimulus(1'b0, 1'b1, 1'b0, a);
      n++;
    end
    checkOutput("drain", 128'(pipeQ.size()), 128'd0);
  endtask

  task automatic directedBeat(input string tag, input int mode, clip, shift,
                              input logic [W-1:0] data, input logic [W-1:0] expData);
    bit a;
    stimMode = mode; stimClip = clip; stimShift = shift; stimData = data;
    fixedExp = expData; useFixed = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, a);
    useFixed = 1'b0;
    checkOutput(tag, 128'(a), 128'd1);
    drain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit a;
    int sent, cyc;
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; clrCnt = 1'b0;
    inData = '0; cfgMode = '0; cfgClip = '0; cfgShift = '0;
    stimData = '0; stimMode = 0; stimClip = 0; stimShift = 0; useFixed = 1'b0; fixedExp = '0;
    modelCnt = 0; modelSatCnt = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", outValid, 1'b0);
    checkOutput("rst_out_data", outData, '0);
    checkOutput("rst_zero_cnt", zeroCnt, 32'd0);
    rst = 1'b0;

    directedBeat("relu_accept", 1, 0, 0, pack4(23'd5, 23'h7FFFFF, 23'h400000, 23'h3FFFFF),
                 pack4(23'd5, 23'd0, 23'd0, 23'h3FFFFF));
    checkOutput("relu_cnt", zeroCnt, 32'd2);
    directedBeat("clip_accept", 2, 100, 0, pack4(23'd250, 23'd100, 23'd99, 23'h7FFFF9),
                 pack4(23'd100, 23'd100, 23'd99, 23'd0));
    checkOutput("clip_cnt", zeroCnt, 32'd3);
    directedBeat("leaky_accept", 3, 0, 2, pack4(23'h7FFFF0, 23'h7FFFFF, 23'd8, 23'd0),
                 pack4(23'h7FFFFC, 23'h7FFFFF, 23'd8, 23'd0));
    directedBeat("leaky0_accept", 3, 0, 0, pack4(23'h7FFFF0, 23'h7FFFFF, 23'd8, 23'd0),
                 pack4(23'h7FFFF0, 23'h7FFFFF, 23'd8, 23'd0));
    checkOutput("leaky_cnt", zeroCnt, 32'd3);

    // Incrementing bypass stream under a stalling consumer with a 5-cycle low run.
    stimMode = 0; sent = 0; cyc = 0;
    while (sent < 20 && cyc < 300) begin
      stimData = pack4(DW'(4*sent), DW'(4*sent+1), DW'(4*sent+2), DW'(4*sent+3));
      applyStimulus(1'b1, (cyc >= 3 && cyc <= 7) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0, a);
      if (a) sent++;
      cyc++;
    end
    checkOutput("stream_sent", 128'(sent), 128'd20);
    drain();

    // Saturation on the 4-bit instance: 4, 8, 12, 15, 15.
    applyStimulus(1'b0, 1'b1, 1'b1, a);
    stimMode = 1;
    for (int k = 0; k < 5; k++) begin
      stimData = pack4(DW'(23'h400000 + k), 23'h7FFFFF, 23'h500000, 23'h7FFF00);
      applyStimulus(1'b1, 1'b1, 1'b0, a);
    end
    drain();
    checkOutput("sat_final", satZeroCnt, 4'd15);
    checkOutput("unsat_final", zeroCnt, 32'd20);

    // Clear coinciding with an accepted output beat wins over its increment.
    applyStimulus(1'b1, 1'b1, 1'b0, a);
    applyStimulus(1'b0, 1'b1, 1'b0, a);
    applyStimulus(1'b0, 1'b1, 1'b1, a);
    checkOutput("clr_priority", zeroCnt, 32'd0);
    drain();

    // Asynchronous reset with two beats in flight.
    stimData = pack4(23'h7FFFFF, 23'd1, 23'd2, 23'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, a);
    drain();
    applyStimulus(1'b1, 1'b0, 1'b0, a);
    applyStimulus(1'b1, 1'b0, 1'b0, a);
    applyStimulus(1'b0, 1'b0, 1'b0, a);
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", outValid, 1'b0);
    checkOutput("arst_zero_cnt", zeroCnt, 32'd0);
    checkOutput("arst_out_data", outData, '0);
    pipeQ.delete();
    modelCnt = 0; modelSatCnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    directedBeat("post_rst_accept", 0, 0, 0, pack4(23'd11, 23'd22, 23'd33, 23'h7FFFFE),
                 pack4(23'd11, 23'd22, 23'd33, 23'h7FFFFE));

    // Fully randomized traffic and configuration.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < L; i++) stimData[i*DW +: DW] = randLane();
      stimMode  = $urandom_range(0, 3);
      stimClip  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4194303)) : int'($urandom_range(0, 300));
      stimShift = $urandom_range(0, 7);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0), a);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
